// File: rtl/bram_be_pipelined_2port.sv
// True-dual-port byte-enabled BRAM with valid/ready request and response
// channels, configurable read latency and credit-counted response queues.
//
// Ports (x in {a,b}):
//   CLK, RST             clock, synchronous active-high reset
//   busy                 high while the post-reset zero-fill runs
//   x_req_valid/ready    request handshake
//   x_req_we             per-lane write enable, all zero = read
//   x_req_addr/data      word address and write data
//   x_rsp_valid/ready    response handshake
//   x_rsp_data           read data (or write data when writes respond)
module bram_be_pipelined_2port #(
    parameter string FILENAME       = "",
    parameter int    BINARY         = 0,
    parameter int    ADDR_WIDTH     = 10,
    parameter int    CHUNKSIZE      = 8,
    parameter int    WE_WIDTH       = 4,
    parameter int    MEMSIZE        = 1024,
    parameter int    LATENCY        = 1,
    parameter int    RSP_Q_DEPTH    = 3,
    parameter int    WRITE_FIRST    = 1,
    parameter int    RSP_ON_WRITE   = 0,
    parameter int    CLEAR_ON_RESET = 0,
    localparam int   DATA_WIDTH     = CHUNKSIZE * WE_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    output logic                  busy,
    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic [WE_WIDTH-1:0]   a_req_we,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0] a_req_data,
    output logic                  a_rsp_valid,
    input  logic                  a_rsp_ready,
    output logic [DATA_WIDTH-1:0] a_rsp_data,
    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic [WE_WIDTH-1:0]   b_req_we,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [DATA_WIDTH-1:0] b_req_data,
    output logic                  b_rsp_valid,
    input  logic                  b_rsp_ready,
    output logic [DATA_WIDTH-1:0] b_rsp_data
);
    localparam int IW = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
    localparam int CW = $clog2(RSP_Q_DEPTH + 1);
    localparam int PW = (RSP_Q_DEPTH > 1) ? $clog2(RSP_Q_DEPTH) : 1;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] clr_q, clr_d;

    logic [DATA_WIDTH-1:0] mem [MEMSIZE];

    logic [1:0]            rv, rr, acc, rsv, rsr, inr;
    logic [WE_WIDTH-1:0]   we    [2];
    logic [ADDR_WIDTH-1:0] ad    [2];
    logic [IW-1:0]         idx   [2];
    logic [DATA_WIDTH-1:0] wd    [2];
    logic [DATA_WIDTH-1:0] old_q [2];
    logic [DATA_WIDTH-1:0] rsd   [2];

    assign rv    = {b_req_valid, a_req_valid};
    assign rsr   = {b_rsp_ready, a_rsp_ready};
    assign we[0] = a_req_we;
    assign we[1] = b_req_we;
    assign ad[0] = a_req_addr;
    assign ad[1] = b_req_addr;
    assign wd[0] = a_req_data;
    assign wd[1] = b_req_data;

    assign a_req_ready = rr[0];
    assign b_req_ready = rr[1];
    assign a_rsp_valid = rsv[0];
    assign b_rsp_valid = rsv[1];
    assign a_rsp_data  = rsd[0];
    assign b_rsp_data  = rsd[1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        unique case (state_q)
            CLEAR: begin
                clr_d = clr_q + IW'(1);
                if (clr_q == IW'(MEMSIZE - 1)) begin
                    state_d = RUN;
                    clr_d   = '0;
                end
            end
            RUN: begin
            end
        endcase
    end

    assign busy = (state_q == CLEAR);

    // Port B is applied first so port A wins lanes both ports enable.
    // The registered read always samples the pre-edge word.
    always_ff @(posedge CLK) begin
        if (state_q == CLEAR) mem[clr_q] <= '0;
        for (int p = 1; p >= 0; p--) begin
            if (acc[p] && inr[p]) begin
                for (int i = 0; i < WE_WIDTH; i++) begin
                    if (we[p][i])
                        mem[idx[p]][i*CHUNKSIZE +: CHUNKSIZE] <=
                            wd[p][i*CHUNKSIZE +: CHUNKSIZE];
                end
            end
            old_q[p] <= inr[p] ? mem[idx[p]] : '0;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic                  needs, s1_v, p_v;
        logic                  push, qpop, pop, q_empty;
        logic [WE_WIDTH-1:0]   s1_we;
        logic [DATA_WIDTH-1:0] s1_wd, s1_d, p_d;
        logic [CW-1:0]         cnt_q, qn_q;
        logic [PW-1:0]         wp_q, rp_q;
        logic [DATA_WIDTH-1:0] q_mem [RSP_Q_DEPTH];

        assign idx[p] = ad[p][IW-1:0];
        assign inr[p] = ({1'b0, ad[p]} < (ADDR_WIDTH + 1)'(MEMSIZE));

        // Only requests that will produce a response consume a credit.
        assign needs  = ~(|we[p]) | (RSP_ON_WRITE != 0);
        assign rr[p]  = ~RST & (state_q == RUN) &
                        (~needs | (cnt_q < CW'(RSP_Q_DEPTH)));
        assign acc[p] = rv[p] & rr[p];

        always_ff @(posedge CLK) begin
            if (RST) s1_v <= 1'b0;
            else     s1_v <= acc[p] & needs;
            s1_we <= we[p];
            s1_wd <= wd[p];
        end

        always_comb begin
            s1_d = old_q[p];
            for (int i = 0; i < WE_WIDTH; i++) begin
                if (s1_we[i] && (WRITE_FIRST != 0))
                    s1_d[i*CHUNKSIZE +: CHUNKSIZE] =
                        s1_wd[i*CHUNKSIZE +: CHUNKSIZE];
            end
        end

        if (LATENCY == 2) begin : g_lat2
            logic                  s2_v;
            logic [DATA_WIDTH-1:0] s2_d;
            always_ff @(posedge CLK) begin
                if (RST) s2_v <= 1'b0;
                else     s2_v <= s1_v;
                s2_d <= s1_d;
            end
            assign p_v = s2_v;
            assign p_d = s2_d;
        end else begin : g_lat1
            assign p_v = s1_v;
            assign p_d = s1_d;
        end

        // Fall-through queue: pipeline output bypasses an empty queue,
        // and is parked in it whenever it cannot be consumed directly.
        assign q_empty = (qn_q == '0);
        assign rsv[p]  = ~q_empty | p_v;
        assign rsd[p]  = ~q_empty ? q_mem[rp_q] : (p_v ? p_d : '0);
        assign pop     = rsv[p] & rsr[p];
        assign qpop    = ~q_empty & rsr[p];
        assign push    = p_v & ~(q_empty & rsr[p]);

        always_ff @(posedge CLK) begin
            if (RST) begin
                cnt_q <= '0;
                qn_q  <= '0;
                wp_q  <= '0;
                rp_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(acc[p] & needs) - CW'(pop);
                qn_q  <= qn_q + CW'(push) - CW'(qpop);
                if (push)
                    wp_q <= (wp_q == PW'(RSP_Q_DEPTH - 1)) ? '0 : wp_q + PW'(1);
                if (qpop)
                    rp_q <= (rp_q == PW'(RSP_Q_DEPTH - 1)) ? '0 : rp_q + PW'(1);
            end
        end

        always_ff @(posedge CLK) begin
            if (push) q_mem[wp_q] <= p_d;
        end
    end
endmodule
